// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch-side program-counter unit.
// Holds the fetch FSM states, instruction size and default boot address.
package pc_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_e;

   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle of redirect, memory request/response and decode hand-off signals.
// The master side is the fetch unit; the slave side is its environment.
interface pc_fetch_unit_if #(
   parameter int BITSIZE = 32
);

   logic               BranchTaken;
   logic [BITSIZE-1:0] BranchTarget;
   logic               Stall;
   logic               FetchReqValid;
   logic               FetchReqReady;
   logic [BITSIZE-1:0] FetchAddr;
   logic               FetchRespValid;
   logic [BITSIZE-1:0] FetchRespData;
   logic               InstrValid;
   logic               InstrReady;
   logic [BITSIZE-1:0] Instr;
   logic [BITSIZE-1:0] InstrPC;
   logic               MisalignErr;

   modport master (
      input  BranchTaken, BranchTarget, Stall, FetchReqReady,
      input  FetchRespValid, FetchRespData, InstrReady,
      output FetchReqValid, FetchAddr, InstrValid, Instr, InstrPC, MisalignErr
   );

   modport slave (
      output BranchTaken, BranchTarget, Stall, FetchReqReady,
      output FetchRespValid, FetchRespData, InstrReady,
      input  FetchReqValid, FetchAddr, InstrValid, Instr, InstrPC, MisalignErr
   );

endinterface

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Next-PC mux: word-aligned redirect target, sequential PC+4, or hold.
// Also flags a redirect target whose low two bits are not zero.
module pc_next_sel
   import pc_fetch_unit_pkg::*;
#(
   parameter int BITSIZE = 32
) (
   input  logic [BITSIZE-1:0] pc_i,
   input  logic               advance_i,
   input  logic               redirect_i,
   input  logic [BITSIZE-1:0] target_i,
   output logic [BITSIZE-1:0] pcNext_o,
   output logic               misalign_o
);

   // Redirect wins over the sequential advance; the increment wraps silently.
   always_comb begin
      pcNext_o = pc_i;
      if (redirect_i) begin
         pcNext_o = {target_i[BITSIZE-1:2], 2'b00};
      end else if (advance_i) begin
         pcNext_o = pc_i + BITSIZE'(INSTR_BYTES);
      end
   end

   assign misalign_o = redirect_i && (target_i[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC owner: one outstanding instruction read, squash on redirect,
// and a one-entry buffer presenting each fetched word with its PC to decode.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int                 BITSIZE  = 32,
   parameter logic [BITSIZE-1:0] RESET_PC = BITSIZE'(DEFAULT_RESET_PC)
) (
   input  logic                   clk,
   input  logic                   rst,
   pc_fetch_unit_if.master        bus
);

   fetch_state_e       state_q, state_d;
   logic [BITSIZE-1:0] pc_q, pc_d;
   logic               squash_q, squash_d;
   logic [BITSIZE-1:0] reqPc_q, reqPc_d;
   logic               instrValid_q, instrValid_d;
   logic [BITSIZE-1:0] instr_q, instr_d;
   logic [BITSIZE-1:0] instrPc_q, instrPc_d;
   logic               misalign_q, misalign_d;
   logic               misalignHit;
   logic               reqValid;
   logic               reqFire;

   assign reqValid = (state_q == ST_ISSUE) && !bus.Stall;
   assign reqFire  = reqValid && bus.FetchReqReady;

   pc_next_sel #(
      .BITSIZE (BITSIZE)
   ) u_next_sel (
      .pc_i       (pc_q),
      .advance_i  (reqFire),
      .redirect_i (bus.BranchTaken),
      .target_i   (bus.BranchTarget),
      .pcNext_o   (pc_d),
      .misalign_o (misalignHit)
   );

   always_comb begin
      state_d      = state_q;
      squash_d     = squash_q;
      reqPc_d      = reqPc_q;
      instrValid_d = instrValid_q;
      instr_d      = instr_q;
      instrPc_d    = instrPc_q;
      misalign_d   = misalign_q | misalignHit;

      unique case (state_q)
         ST_ISSUE: begin
            // A redirect coinciding with acceptance makes the accepted read stale.
            if (reqFire) begin
               reqPc_d  = pc_q;
               squash_d = bus.BranchTaken;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.BranchTaken) begin
               if (bus.FetchRespValid) begin
                  squash_d = 1'b0;
                  state_d  = ST_ISSUE;
               end else begin
                  squash_d = 1'b1;
               end
            end else if (bus.FetchRespValid) begin
               if (squash_q) begin
                  squash_d = 1'b0;
                  state_d  = ST_ISSUE;
               end else begin
                  instr_d      = bus.FetchRespData;
                  instrPc_d    = reqPc_q;
                  instrValid_d = 1'b1;
                  state_d      = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (bus.BranchTaken || bus.InstrReady) begin
               instrValid_d = 1'b0;
               state_d      = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_ISSUE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ISSUE;
         pc_q         <= RESET_PC;
         squash_q     <= 1'b0;
         reqPc_q      <= '0;
         instrValid_q <= 1'b0;
         instr_q      <= '0;
         instrPc_q    <= '0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         squash_q     <= squash_d;
         reqPc_q      <= reqPc_d;
         instrValid_q <= instrValid_d;
         instr_q      <= instr_d;
         instrPc_q    <= instrPc_d;
         misalign_q   <= misalign_d;
      end
   end

   assign bus.FetchReqValid = reqValid;
   assign bus.FetchAddr     = pc_q;
   assign bus.InstrValid    = instrValid_q;
   assign bus.Instr         = instr_q;
   assign bus.InstrPC       = instrPc_q;
   assign bus.MisalignErr   = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a small instruction memory with selectable
// latency answers each accepted request; each scenario task checks its own results.
module tb_pc_fetch_unit;

   logic clk = 1'b0;
   logic rst;

   pc_fetch_unit_if #(.BITSIZE(32)) bus ();

   pc_fetch_unit #(
      .BITSIZE  (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          passed = 0;
   int          memLatency = 1;
   int          pendCnt = 0;
   logic [31:0] pendAddr = 32'h0;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   // One clock: note whether a request is accepted, then present the memory
   // response (if due) just after the edge. Redirect strobes last one cycle.
   task automatic step();
      logic        fire;
      logic [31:0] addr;
      #1;
      fire = !rst && bus.FetchReqValid && bus.FetchReqReady;
      addr = bus.FetchAddr;
      @(posedge clk);
      #1;
      bus.BranchTaken = 1'b0;
      if (rst) begin
         pendCnt = 0;
      end else if (fire) begin
         pendCnt  = memLatency;
         pendAddr = addr;
      end else if (pendCnt > 0) begin
         pendCnt--;
      end
      bus.FetchRespValid = (pendCnt == 1);
      bus.FetchRespData  = (pendCnt == 1) ? memWord(pendAddr) : 32'hDEAD_BEEF;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      checks++; if (bus.FetchAddr !== 32'h0) $display("[TB] FAIL reset_addr got %h want %h", bus.FetchAddr, 32'h0); else passed++;
      checks++; if (bus.FetchReqValid !== 1'b1) $display("[TB] FAIL reset_reqvalid got %b want 1", bus.FetchReqValid); else passed++;
      checks++; if (bus.InstrValid !== 1'b0) $display("[TB] FAIL reset_instrvalid got %b want 0", bus.InstrValid); else passed++;
      checks++; if (bus.Instr !== 32'h0) $display("[TB] FAIL reset_instr got %h want 0", bus.Instr); else passed++;
      checks++; if (bus.InstrPC !== 32'h0) $display("[TB] FAIL reset_instrpc got %h want 0", bus.InstrPC); else passed++;
      checks++; if (bus.MisalignErr !== 1'b0) $display("[TB] FAIL reset_misalign got %b want 0", bus.MisalignErr); else passed++;
   endtask

   task automatic test_free_run();
      logic [31:0] a;
      for (int i = 0; i < 2; i++) begin
         a = 32'(i * 4);
         checks++; if (bus.FetchReqValid !== 1'b1 || bus.FetchAddr !== a) $display("[TB] FAIL free_issue got %b/%h want 1/%h", bus.FetchReqValid, bus.FetchAddr, a); else passed++;
         step();
         checks++; if (bus.FetchReqValid !== 1'b0) $display("[TB] FAIL free_wait_reqvalid got %b want 0", bus.FetchReqValid); else passed++;
         step();
         checks++; if (bus.InstrValid !== 1'b1 || bus.InstrPC !== a || bus.Instr !== memWord(a)) $display("[TB] FAIL free_deliver got %b/%h/%h want 1/%h/%h", bus.InstrValid, bus.InstrPC, bus.Instr, a, memWord(a)); else passed++;
         step();
         checks++; if (bus.InstrValid !== 1'b0) $display("[TB] FAIL free_consumed got %b want 0", bus.InstrValid); else passed++;
      end
      checks++; if (bus.FetchAddr !== 32'h8) $display("[TB] FAIL free_third_addr got %h want 8", bus.FetchAddr); else passed++;
   endtask

   task automatic test_stall();
      logic [31:0] a;
      bus.Stall = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.FetchReqValid !== 1'b0 || bus.FetchAddr !== 32'h8) $display("[TB] FAIL stall_hold cyc %0d got %b/%h want 0/8", i, bus.FetchReqValid, bus.FetchAddr); else passed++;
         step();
      end
      bus.Stall = 1'b0;
      #1;
      checks++; if (bus.FetchReqValid !== 1'b1 || bus.FetchAddr !== 32'h8) $display("[TB] FAIL stall_resume got %b/%h want 1/8", bus.FetchReqValid, bus.FetchAddr); else passed++;
      for (int i = 0; i < 2; i++) begin
         a = 32'h8 + 32'(i * 4);
         step();
         step();
         checks++; if (bus.InstrPC !== a || bus.Instr !== memWord(a)) $display("[TB] FAIL stall_after got %h/%h want %h/%h", bus.InstrPC, bus.Instr, a, memWord(a)); else passed++;
         step();
      end
   endtask

   task automatic test_redirect_wait();
      memLatency = 2;
      checks++; if (bus.FetchAddr !== 32'h10) $display("[TB] FAIL rw_start_addr got %h want 10", bus.FetchAddr); else passed++;
      step();
      bus.BranchTaken  = 1'b1;
      bus.BranchTarget = 32'h100;
      step();
      checks++; if (bus.InstrValid !== 1'b0 || bus.FetchReqValid !== 1'b0) $display("[TB] FAIL rw_squash_wait got %b/%b want 0/0", bus.InstrValid, bus.FetchReqValid); else passed++;
      step();
      checks++; if (bus.InstrValid !== 1'b0) $display("[TB] FAIL rw_dropped got %b want 0", bus.InstrValid); else passed++;
      checks++; if (bus.FetchReqValid !== 1'b1 || bus.FetchAddr !== 32'h100) $display("[TB] FAIL rw_new_addr got %b/%h want 1/100", bus.FetchReqValid, bus.FetchAddr); else passed++;
      memLatency = 1;
      step();
      step();
      checks++; if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h100 || bus.Instr !== memWord(32'h100)) $display("[TB] FAIL rw_deliver got %b/%h/%h want 1/100/%h", bus.InstrValid, bus.InstrPC, bus.Instr, memWord(32'h100)); else passed++;
      step();
   endtask

   task automatic test_redirect_issue();
      bus.Stall        = 1'b1;
      bus.BranchTaken  = 1'b1;
      bus.BranchTarget = 32'h14;
      step();
      checks++; if (bus.FetchAddr !== 32'h14 || bus.FetchReqValid !== 1'b0) $display("[TB] FAIL ri_idle got %b/%h want 0/14", bus.FetchReqValid, bus.FetchAddr); else passed++;
      bus.Stall        = 1'b0;
      bus.BranchTaken  = 1'b1;
      bus.BranchTarget = 32'h200;
      step();
      checks++; if (bus.FetchReqValid !== 1'b0) $display("[TB] FAIL ri_wait got %b want 0", bus.FetchReqValid); else passed++;
      step();
      checks++; if (bus.InstrValid !== 1'b0 || bus.FetchAddr !== 32'h200) $display("[TB] FAIL ri_squashed got %b/%h want 0/200", bus.InstrValid, bus.FetchAddr); else passed++;
   endtask

   task automatic test_hold_redirect();
      bus.InstrReady = 1'b0;
      step();
      step();
      checks++; if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h200 || bus.Instr !== memWord(32'h200)) $display("[TB] FAIL hr_enter got %b/%h/%h want 1/200/%h", bus.InstrValid, bus.InstrPC, bus.Instr, memWord(32'h200)); else passed++;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h200 || bus.Instr !== memWord(32'h200)) $display("[TB] FAIL hr_stable cyc %0d got %b/%h/%h", i, bus.InstrValid, bus.InstrPC, bus.Instr); else passed++;
      end
      bus.InstrReady   = 1'b1;
      bus.BranchTaken  = 1'b1;
      bus.BranchTarget = 32'h40;
      step();
      checks++; if (bus.InstrValid !== 1'b0 || bus.FetchReqValid !== 1'b1 || bus.FetchAddr !== 32'h40) $display("[TB] FAIL hr_redirect got %b/%b/%h want 0/1/40", bus.InstrValid, bus.FetchReqValid, bus.FetchAddr); else passed++;
      step();
      step();
      checks++; if (bus.InstrPC !== 32'h40 || bus.Instr !== memWord(32'h40)) $display("[TB] FAIL hr_after got %h/%h want 40/%h", bus.InstrPC, bus.Instr, memWord(32'h40)); else passed++;
      step();
   endtask

   task automatic test_wrap();
      bus.Stall        = 1'b1;
      bus.BranchTaken  = 1'b1;
      bus.BranchTarget = 32'hFFFF_FFFC;
      step();
      bus.Stall = 1'b0;
      #1;
      checks++; if (bus.FetchAddr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_top got %h want fffffffc", bus.FetchAddr); else passed++;
      step();
      step();
      checks++; if (bus.InstrPC !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_instrpc got %h want fffffffc", bus.InstrPC); else passed++;
      step();
      checks++; if (bus.FetchAddr !== 32'h0) $display("[TB] FAIL wrap_next got %h want 0", bus.FetchAddr); else passed++;
   endtask

   task automatic test_misalign_reset();
      bus.Stall        = 1'b1;
      bus.BranchTaken  = 1'b1;
      bus.BranchTarget = 32'h103;
      step();
      checks++; if (bus.MisalignErr !== 1'b1 || bus.FetchAddr !== 32'h100) $display("[TB] FAIL mis_set got %b/%h want 1/100", bus.MisalignErr, bus.FetchAddr); else passed++;
      bus.Stall  = 1'b0;
      memLatency = 2;
      step();
      checks++; if (bus.MisalignErr !== 1'b1 || bus.FetchReqValid !== 1'b0) $display("[TB] FAIL mis_sticky got %b/%b want 1/0", bus.MisalignErr, bus.FetchReqValid); else passed++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++; if (bus.FetchAddr !== 32'h0 || bus.FetchReqValid !== 1'b1) $display("[TB] FAIL mis_rst_pc got %b/%h want 1/0", bus.FetchReqValid, bus.FetchAddr); else passed++;
      checks++; if (bus.MisalignErr !== 1'b0 || bus.InstrValid !== 1'b0) $display("[TB] FAIL mis_rst_flags got %b/%b want 0/0", bus.MisalignErr, bus.InstrValid); else passed++;
      checks++; if (bus.Instr !== 32'h0 || bus.InstrPC !== 32'h0) $display("[TB] FAIL mis_rst_buf got %h/%h want 0/0", bus.Instr, bus.InstrPC); else passed++;
      memLatency = 1;
      step();
      step();
      checks++; if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h0 || bus.Instr !== memWord(32'h0)) $display("[TB] FAIL mis_refetch got %b/%h/%h want 1/0/%h", bus.InstrValid, bus.InstrPC, bus.Instr, memWord(32'h0)); else passed++;
   endtask

   initial begin
      rst                = 1'b1;
      bus.BranchTaken    = 1'b0;
      bus.BranchTarget   = 32'h0;
      bus.Stall          = 1'b0;
      bus.FetchReqReady  = 1'b1;
      bus.FetchRespValid = 1'b0;
      bus.FetchRespData  = 32'h0;
      bus.InstrReady     = 1'b1;
      test_reset();
      test_free_run();
      test_stall();
      test_redirect_wait();
      test_redirect_issue();
      test_hold_redirect();
      test_wrap();
      test_misalign_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch-side program-counter owner for the RISC-V core.
- Holds the architectural fetch PC and issues one instruction-memory read at a time over a valid/ready request channel.
- Returns each fetched word with its PC to decode through a one-entry output buffer.
- Consumes the branch-target adder output as a redirect: it is the receiving end of the branch target path.

Parameters:
- BITSIZE, 32, width of PC, addresses and instruction words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- BranchTaken  in  1  single-cycle redirect strobe from execute.
- BranchTarget  in  BITSIZE  redirect address, valid while BranchTaken=1.
- Stall  in  1  pipeline stall; suppresses new fetch requests.
- FetchReqValid  out  1  request to instruction memory.
- FetchReqReady  in  1  memory accepts the request.
- FetchAddr  out  BITSIZE  request address.
- FetchRespValid  in  1  read data valid; exactly one response per accepted request, at least 1 cycle after acceptance.
- FetchRespData  in  BITSIZE  instruction word.
- InstrValid  out  1  buffered instruction available to decode.
- InstrReady  in  1  decode consumes the instruction.
- Instr  out  BITSIZE  instruction word.
- InstrPC  out  BITSIZE  PC of Instr.
- MisalignErr  out  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset: rst sampled high at a clock edge sets all of the following, regardless of state or any outstanding request:
  - PC=RESET_PC, state=ISSUE, Squash=0, ReqPC=0.
  - InstrValid=0, Instr=0, InstrPC=0, MisalignErr=0.
  - A response for a pre-reset request is the environment's responsibility; the memory is reset together with this block.
- States: ISSUE, WAIT, HOLD.
- ISSUE:
  - FetchReqValid = !Stall; FetchAddr = PC (combinational from the PC register).
  - On FetchReqValid && FetchReqReady: ReqPC<=PC, PC<=PC+4 (modulo 2^BITSIZE, wraps silently), go to WAIT.
- WAIT:
  - FetchReqValid=0.
  - On FetchRespValid with Squash=1: discard the data, clear Squash, go to ISSUE.
  - On FetchRespValid with Squash=0: Instr<=FetchRespData, InstrPC<=ReqPC, InstrValid<=1, go to HOLD.
- HOLD:
  - InstrValid=1, held stable until InstrValid && InstrReady; then InstrValid<=0 and go to ISSUE.
  - Minimum request-to-request spacing is therefore 3 cycles: issue, response, consume.
- Redirect (BranchTaken=1) has priority over all other events in the same cycle:
  - PC<=BranchTarget with bits [1:0] forced to 0.
  - If BranchTarget[1:0]!=0, MisalignErr<=1 and it stays set until rst.
  - In ISSUE with no handshake in that cycle: stay in ISSUE; the next FetchAddr is the new target. Withdrawing or changing a pending request on redirect is a permitted protocol exception.
  - In ISSUE with a handshake in the same cycle: the accepted request is stale. Go to WAIT with Squash<=1; PC takes the target, not PC+4.
  - In WAIT: Squash<=1, stay in WAIT. A FetchRespValid in the same cycle is discarded and the FSM goes to ISSUE with Squash=0.
  - In HOLD: InstrValid<=0 and go to ISSUE, even if InstrReady=1 in the same cycle; that instruction is not delivered.
- Stall:
  - Affects only request issue in ISSUE.
  - Does not block responses, HOLD hand-off, or redirects.
- Only one request is ever outstanding; Squash is a single bit.
- No combinational path from FetchRespValid/FetchRespData to any output; FetchReqValid depends combinationally on Stall only.

Decomposition:
- Shared package/header: state encoding constants (ST_ISSUE, ST_WAIT, ST_HOLD), INSTR_BYTES=4, default RESET_PC.
- One sub-module is natural: pc_next_sel, a combinational next-PC mux (redirect-aligned target / PC+4 / hold) that also produces the misalign detect.
- FSM, Squash, ReqPC and the output buffer stay in the top module.

Test Plan:
- Reset then free-run, FetchReqReady=1, 1-cycle memory latency, InstrReady=1 -> FetchAddr sequence 0x0,0x4,0x8 on every 3rd cycle; InstrPC matches each address; Instr equals memory contents.
- Stall=1 for 5 cycles while in ISSUE -> FetchReqValid=0 throughout; PC stays 0x8; fetch resumes at 0x8 the cycle after Stall drops.
- BranchTaken with target 0x100 while in WAIT for the request to 0x10 -> response for 0x10 dropped (InstrValid stays 0); next FetchAddr=0x100; InstrPC=0x100.
- BranchTaken with target 0x200 in the same cycle as the handshake for 0x14 -> 0x14 response squashed; next request 0x200; PC never takes 0x18.
- InstrReady=0 in HOLD for 4 cycles, then BranchTaken with target 0x40 -> Instr/InstrPC stable for 4 cycles; InstrValid drops; next fetch at 0x40 with no instruction delivered.
- BranchTaken with target 0x103 -> MisalignErr=1 and stays set; FetchAddr=0x100; rst mid-WAIT -> PC=RESET_PC, MisalignErr=0, InstrValid=0.
